alu_arbiter: RTL

//  Shares one combinational alu (16-bit, alucont[2:0]) between two requesters (0, 1).

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters; IDLE->EXEC->RESP, one op per 3 cycles.
// Optional grant counters enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cont,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
`endif
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [2:0]         op_cont_q, op_cont_d;
    logic [WIDTH-1:0]   res0_q, res0_d;
    logic [WIDTH-1:0]   res1_q, res1_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic               grant0, grant1;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]        cnt0_q, cnt0_d;
    logic [15:0]        cnt1_q, cnt1_d;
`endif

    always_comb begin
        // Tie goes to whoever did not win last; last_grant resets to 1 so req0 wins first.
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = !reset && (state_q == IDLE) && grant0;
        req1_ready = !reset && (state_q == IDLE) && grant1;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_cont_d    = op_cont_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;

        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    op_a_d       = req0_a;
                    op_b_d       = req0_b;
                    op_cont_d    = req0_op;
                    state_d      = EXEC;
                end else if (req1_ready) begin
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    op_a_d       = req1_a;
                    op_b_d       = req1_b;
                    op_cont_d    = req1_op;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    res1_d       = alu_result;
                    rsp1_valid_d = 1'b1;
                end else begin
                    res0_d       = alu_result;
                    rsp0_valid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ALU_ARB_STATS_EN
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req0_ready && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
        if (req1_ready && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_cont_q    <= 3'b000;
            res0_q       <= '0;
            res1_q       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_STATS_EN
            cnt0_q       <= 16'd0;
            cnt1_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cont_q    <= op_cont_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_ARB_STATS_EN
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
`endif
        end
    end

    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_cont    = op_cont_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = res0_q;
    assign rsp1_result = res1_q;
`ifdef ALU_ARB_STATS_EN
    assign grant_cnt0  = cnt0_q;
    assign grant_cnt1  = cnt1_q;
`endif

endmodule
